// File: rtl/avmm_wr_credit_gate_if.sv
// Kernel-side write handshake bundle: upstream write/waitrequest, downstream write/waitrequest and per-word acks.
// The gate takes the slave modport; the kernel side (or a bench) drives through the master modport.
interface avmm_wr_credit_gate_if #(
    parameter int AVMM_BURSTCNT_WIDTH = 5
);
    logic                           up_wr;
    logic [AVMM_BURSTCNT_WIDTH-1:0] up_burstcnt;
    logic                           up_waitreq;
    logic                           dn_wr;
    logic                           dn_waitreq;
    logic                           wr_ack_word_in;
    logic                           wr_ack_word_out;

    modport master (
        output up_wr,
        output up_burstcnt,
        input  up_waitreq,
        input  dn_wr,
        output dn_waitreq,
        output wr_ack_word_in,
        input  wr_ack_word_out
    );

    modport slave (
        input  up_wr,
        input  up_burstcnt,
        output up_waitreq,
        output dn_wr,
        input  dn_waitreq,
        input  wr_ack_word_in,
        output wr_ack_word_out
    );
endinterface

// File: rtl/avmm_wr_credit_gate.sv
// Write-credit gate: reserves a burst's words on its first beat, frees one per ack; gating is zero-latency, ack return 1 cycle.
// First beats stall on up_waitreq when credit is short; ASP_WR_CREDIT_TIMEOUT_EN adds a sticky ack watchdog.
module avmm_wr_credit_gate #(
    parameter int LOCAL_MEM_BURST_CNT_WIDTH = 5,
    parameter int AVMM_BURSTCNT_WIDTH       = LOCAL_MEM_BURST_CNT_WIDTH,
    parameter int MAX_OUTSTANDING_WORDS     = 256,
    parameter int CNT_WIDTH                 = $clog2(MAX_OUTSTANDING_WORDS + 1),
    parameter int TIMEOUT_CYCLES            = 65536
) (
    input  logic                 kernel_avmm_clk,
    input  logic                 kernel_avmm_reset,
    avmm_wr_credit_gate_if.slave bus,
    output logic [CNT_WIDTH-1:0] outstanding_words,
    output logic                 credit_stall,
    output logic                 err_underflow,
    output logic                 err_timeout
);
    localparam int W     = AVMM_BURSTCNT_WIDTH;
    localparam int SUM_W = ((CNT_WIDTH > W) ? CNT_WIDTH : W) + 1;

    logic [1:0]           reset_d;
    logic                 rst_int;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [W-1:0]         beats_left_q, beats_left_d;
    logic                 first_beat_q, first_beat_d;
    logic                 err_uf_q, err_uf_d;
    logic                 ack_q;

    logic [W-1:0]         eff_bc;
    logic [SUM_W-1:0]     sum_chk;
    logic [SUM_W-1:0]     res;
    logic [SUM_W-1:0]     cnt_nxt;
    logic                 credit_ok;
    logic                 accept;
    logic                 first_acc;
    logic                 later_acc;
    logic                 underflow;

    // Assert asynchronously, release two edges after the external reset drops.
    always_ff @(posedge kernel_avmm_clk or posedge kernel_avmm_reset) begin
        if (kernel_avmm_reset) begin
            reset_d <= 2'b11;
        end else begin
            reset_d <= {reset_d[0], 1'b0};
        end
    end
    assign rst_int = reset_d[1];

    // A zero burstcount still moves one word, so it reserves one credit.
    assign eff_bc    = (bus.up_burstcnt == '0) ? W'(1) : bus.up_burstcnt;
    assign sum_chk   = SUM_W'(cnt_q) + SUM_W'(eff_bc);
    assign credit_ok = (sum_chk <= SUM_W'(MAX_OUTSTANDING_WORDS));

    assign credit_stall    = bus.up_wr && first_beat_q && !credit_ok;
    assign bus.up_waitreq  = bus.dn_waitreq || credit_stall;
    assign bus.dn_wr       = bus.up_wr && !credit_stall;
    assign bus.wr_ack_word_out = ack_q;

    assign accept    = bus.up_wr && !bus.up_waitreq;
    assign first_acc = accept && first_beat_q;
    assign later_acc = accept && !first_beat_q;

    always_comb begin
        beats_left_d = beats_left_q;
        first_beat_d = first_beat_q;
        if (first_acc) begin
            beats_left_d = eff_bc - W'(1);
            first_beat_d = (eff_bc == W'(1));
        end else if (later_acc) begin
            beats_left_d = beats_left_q - W'(1);
            first_beat_d = (beats_left_q == W'(1));
        end
    end

    // Reserve and release net in one step; an ack with nothing to release is the only underflow.
    always_comb begin
        res       = first_acc ? SUM_W'(eff_bc) : '0;
        cnt_nxt   = SUM_W'(cnt_q) + res - SUM_W'(bus.wr_ack_word_in);
        underflow = bus.wr_ack_word_in && (cnt_q == '0) && !first_acc;
        cnt_d     = underflow ? '0 : cnt_nxt[CNT_WIDTH-1:0];
        err_uf_d  = err_uf_q || underflow;
    end

    always_ff @(posedge kernel_avmm_clk or posedge rst_int) begin
        if (rst_int) begin
            cnt_q        <= '0;
            beats_left_q <= '0;
            first_beat_q <= 1'b1;
            err_uf_q     <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            beats_left_q <= beats_left_d;
            first_beat_q <= first_beat_d;
            err_uf_q     <= err_uf_d;
            ack_q        <= bus.wr_ack_word_in;
        end
    end

    assign outstanding_words = cnt_q;
    assign err_underflow     = err_uf_q;

`ifdef ASP_WR_CREDIT_TIMEOUT_EN
    localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT_CYCLES);

    logic [16:0] wd_q, wd_d;
    logic        err_to_q, err_to_d;

    // Counts ack-less cycles with words in flight; saturates at the limit.
    always_comb begin
        wd_d = wd_q;
        if (bus.wr_ack_word_in || (cnt_q == '0)) begin
            wd_d = '0;
        end else if (wd_q != TO_LIMIT) begin
            wd_d = wd_q + 17'd1;
        end
        err_to_d = err_to_q || (wd_d == TO_LIMIT);
    end

    always_ff @(posedge kernel_avmm_clk or posedge rst_int) begin
        if (rst_int) begin
            wd_q     <= '0;
            err_to_q <= 1'b0;
        end else begin
            wd_q     <= wd_d;
            err_to_q <= err_to_d;
        end
    end

    assign err_timeout = err_to_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule
